noc_mmio_port: RTL and testbench

NOC_MMIO_PORT -- requirements
Module: noc_mmio_port

---
 rtl/noc_mmio_port_pkg.sv | 73 +++++++
 rtl/noc_mmio_port_fifo.sv | 63 ++++++
 rtl/noc_mmio_port.sv | 211 +++++++++++++++++++++
 tb/tb_noc_mmio_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_mmio_port_pkg.sv
// Shared definitions for the NoC MMIO port: register map, packet width and
// field slice positions (packed MSB-first as x, y, mcast, done, result, mtype,
// mx, my, elem).
package noc_mmio_port_pkg;

    // Register byte offsets within the window
    localparam logic [7:0] OFF_X         = 8'h00;
    localparam logic [7:0] OFF_Y         = 8'h04;
    localparam logic [7:0] OFF_MCAST     = 8'h08;
    localparam logic [7:0] OFF_DONE      = 8'h0C;
    localparam logic [7:0] OFF_RESULT    = 8'h10;
    localparam logic [7:0] OFF_MTYPE     = 8'h14;
    localparam logic [7:0] OFF_MX        = 8'h18;
    localparam logic [7:0] OFF_MY        = 8'h1C;
    localparam logic [7:0] OFF_ELEM      = 8'h20;
    localparam logic [7:0] OFF_PUSH      = 8'h24;
    localparam logic [7:0] OFF_POP       = 8'h28;
    localparam logic [7:0] OFF_STATUS    = 8'h2C;
    localparam logic [7:0] OFF_RX_X      = 8'h30;
    localparam logic [7:0] OFF_RX_Y      = 8'h34;
    localparam logic [7:0] OFF_RX_MCAST  = 8'h38;
    localparam logic [7:0] OFF_RX_DONE   = 8'h3C;
    localparam logic [7:0] OFF_RX_RESULT = 8'h40;
    localparam logic [7:0] OFF_RX_MTYPE  = 8'h44;
    localparam logic [7:0] OFF_RX_MX     = 8'h48;
    localparam logic [7:0] OFF_RX_MY     = 8'h4C;
    localparam logic [7:0] OFF_RX_ELEM   = 8'h50;
    localparam logic [7:0] OFF_DROP      = 8'h54;

    localparam logic [31:0] WINDOW_BYTES = 32'h58;

    // The three fixed control bits: one done flag and a two-bit result code
    localparam int DONE_BITS   = 1;
    localparam int RESULT_BITS = 2;

    function automatic int packet_bits(int cb, int mb, int tb, int mcb, int eb);
        return 2*cb + mb + DONE_BITS + RESULT_BITS + tb + 2*mcb + eb;
    endfunction

    // LSB position of each field; elem sits at bit 0
    function automatic int my_lsb(int eb);
        return eb;
    endfunction

    function automatic int mx_lsb(int mcb, int eb);
        return eb + mcb;
    endfunction

    function automatic int mtype_lsb(int mcb, int eb);
        return eb + 2*mcb;
    endfunction

    function automatic int result_lsb(int tb, int mcb, int eb);
        return mtype_lsb(mcb, eb) + tb;
    endfunction

    function automatic int done_lsb(int tb, int mcb, int eb);
        return result_lsb(tb, mcb, eb) + RESULT_BITS;
    endfunction

    function automatic int mcast_lsb(int tb, int mcb, int eb);
        return done_lsb(tb, mcb, eb) + DONE_BITS;
    endfunction

    function automatic int y_lsb(int mb, int tb, int mcb, int eb);
        return mcast_lsb(tb, mcb, eb) + mb;
    endfunction

    function automatic int x_lsb(int cb, int mb, int tb, int mcb, int eb);
        return y_lsb(mb, tb, mcb, eb) + cb;
    endfunction

endpackage

// File: rtl/noc_mmio_port_fifo.sv
// Synchronous FIFO used for both packet directions. A pop on a full FIFO
// frees the slot that a push in the same cycle then fills.
module mmio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_mmio_port.sv
// Memory-mapped NoC port: CPU stages packet fields, pushes them into a TX
// FIFO toward the network, and pops received packets out of an RX FIFO.
module noc_mmio_port
    import noc_mmio_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          COORD_BITS  = 1,
    parameter int          MCAST_BITS  = 1,
    parameter int          MTYPE_BITS  = 1,
    parameter int          MCOORD_BITS = 8,
    parameter int          ELEM_BITS   = 32,
    parameter int          TX_DEPTH    = 4,
    parameter int          RX_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_hit,
    output logic [packet_bits(COORD_BITS, MCAST_BITS, MTYPE_BITS, MCOORD_BITS, ELEM_BITS)-1:0] tx_packet,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [packet_bits(COORD_BITS, MCAST_BITS, MTYPE_BITS, MCOORD_BITS, ELEM_BITS)-1:0] rx_packet,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    localparam int PB    = packet_bits(COORD_BITS, MCAST_BITS, MTYPE_BITS, MCOORD_BITS, ELEM_BITS);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    localparam int L_MY     = my_lsb(ELEM_BITS);
    localparam int L_MX     = mx_lsb(MCOORD_BITS, ELEM_BITS);
    localparam int L_MTYPE  = mtype_lsb(MCOORD_BITS, ELEM_BITS);
    localparam int L_RESULT = result_lsb(MTYPE_BITS, MCOORD_BITS, ELEM_BITS);
    localparam int L_DONE   = done_lsb(MTYPE_BITS, MCOORD_BITS, ELEM_BITS);
    localparam int L_MCAST  = mcast_lsb(MTYPE_BITS, MCOORD_BITS, ELEM_BITS);
    localparam int L_Y      = y_lsb(MCAST_BITS, MTYPE_BITS, MCOORD_BITS, ELEM_BITS);
    localparam int L_X      = x_lsb(COORD_BITS, MCAST_BITS, MTYPE_BITS, MCOORD_BITS, ELEM_BITS);

    // Address decode
    logic [31:0] offset;
    logic [7:0]  word_off;
    logic        in_win;
    logic        wr_hit;
    logic        rd_hit;

    assign offset   = bus_addr - BASE_ADDR;
    assign word_off = offset[7:0] & 8'hFC;
    assign in_win   = (bus_addr >= BASE_ADDR) && (offset < WINDOW_BYTES);
    assign wr_hit   = bus_wr && in_win;
    assign rd_hit   = bus_rd && in_win;

    // Staging registers
    logic [COORD_BITS-1:0]  stg_x;
    logic [COORD_BITS-1:0]  stg_y;
    logic [MCAST_BITS-1:0]  stg_mcast;
    logic [DONE_BITS-1:0]   stg_done;
    logic [RESULT_BITS-1:0] stg_result;
    logic [MTYPE_BITS-1:0]  stg_mtype;
    logic [MCOORD_BITS-1:0] stg_mx;
    logic [MCOORD_BITS-1:0] stg_my;
    logic [ELEM_BITS-1:0]   stg_elem;
    logic [PB-1:0]          stg_packet;

    assign stg_packet = {stg_x, stg_y, stg_mcast, stg_done, stg_result,
                         stg_mtype, stg_mx, stg_my, stg_elem};

    // FIFO control and status
    logic             tx_push;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_empty;
    logic [TX_CW-1:0] tx_count;
    logic [PB-1:0]    tx_head;
    logic             tx_drop;

    logic             rx_push;
    logic             rx_pop;
    logic             rx_full;
    logic             rx_empty;
    logic [RX_CW-1:0] rx_count;
    logic [PB-1:0]    rx_head_raw;
    logic [PB-1:0]    rx_head;
    logic             irq_next;

    logic [15:0]      drop;
    logic [31:0]      rd_val;
    logic [31:0]      tx_cnt_w;
    logic [31:0]      rx_cnt_w;

    assign tx_push  = wr_hit && (word_off == OFF_PUSH);
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_drop  = tx_push && tx_full && !tx_pop;
    assign tx_packet = tx_empty ? '0 : tx_head;

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = wr_hit && (word_off == OFF_POP);
    assign rx_head  = rx_empty ? '0 : rx_head_raw;

    // irq tracks whether the RX FIFO will hold anything after this edge
    assign irq_next = rx_push || (rx_count > RX_CW'(1)) || (!rx_empty && !rx_pop);

    assign tx_cnt_w = 32'(tx_count);
    assign rx_cnt_w = 32'(rx_count);

    mmio_sync_fifo #(.WIDTH(PB), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (stg_packet),
        .rdata (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    mmio_sync_fifo #(.WIDTH(PB), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_packet),
        .rdata (rx_head_raw),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Staging field writes; each field keeps the low bits of the write data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_x      <= '0;
            stg_y      <= '0;
            stg_mcast  <= '0;
            stg_done   <= '0;
            stg_result <= '0;
            stg_mtype  <= '0;
            stg_mx     <= '0;
            stg_my     <= '0;
            stg_elem   <= '0;
        end else if (wr_hit) begin
            case (word_off)
                OFF_X:      stg_x      <= bus_wdata[COORD_BITS-1:0];
                OFF_Y:      stg_y      <= bus_wdata[COORD_BITS-1:0];
                OFF_MCAST:  stg_mcast  <= bus_wdata[MCAST_BITS-1:0];
                OFF_DONE:   stg_done   <= bus_wdata[DONE_BITS-1:0];
                OFF_RESULT: stg_result <= bus_wdata[RESULT_BITS-1:0];
                OFF_MTYPE:  stg_mtype  <= bus_wdata[MTYPE_BITS-1:0];
                OFF_MX:     stg_mx     <= bus_wdata[MCOORD_BITS-1:0];
                OFF_MY:     stg_my     <= bus_wdata[MCOORD_BITS-1:0];
                OFF_ELEM:   stg_elem   <= bus_wdata[ELEM_BITS-1:0];
                default:    ;
            endcase
        end
    end

    // Saturating count of packets dropped on a full TX FIFO; a write clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop <= '0;
        end else if (wr_hit && (word_off == OFF_DROP)) begin
            drop <= '0;
        end else if (tx_drop && (drop != 16'hFFFF)) begin
            drop <= drop + 16'd1;
        end
    end

    // Read data selection; RX head fields read as zero when the FIFO is empty
    always_comb begin
        rd_val = '0;
        case (word_off)
            OFF_STATUS:    rd_val = {8'h00, rx_cnt_w[7:0], tx_cnt_w[7:0],
                                     6'b0, !rx_empty, !tx_full};
            OFF_RX_X:      rd_val = 32'(rx_head[L_X      +: COORD_BITS]);
            OFF_RX_Y:      rd_val = 32'(rx_head[L_Y      +: COORD_BITS]);
            OFF_RX_MCAST:  rd_val = 32'(rx_head[L_MCAST  +: MCAST_BITS]);
            OFF_RX_DONE:   rd_val = 32'(rx_head[L_DONE   +: DONE_BITS]);
            OFF_RX_RESULT: rd_val = 32'(rx_head[L_RESULT +: RESULT_BITS]);
            OFF_RX_MTYPE:  rd_val = 32'(rx_head[L_MTYPE  +: MTYPE_BITS]);
            OFF_RX_MX:     rd_val = 32'(rx_head[L_MX     +: MCOORD_BITS]);
            OFF_RX_MY:     rd_val = 32'(rx_head[L_MY     +: MCOORD_BITS]);
            OFF_RX_ELEM:   rd_val = 32'(rx_head[0        +: ELEM_BITS]);
            OFF_DROP:      rd_val = 32'(drop);
            default:       rd_val = '0;
        endcase
    end

    // Registered bus response and interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_rdata <= '0;
            bus_hit   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            bus_hit <= (bus_rd || bus_wr) && in_win;
            irq     <= irq_next;
            if (rd_hit) begin
                bus_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_noc_mmio_port.sv
// Directed bench for noc_mmio_port with default parameters (55-bit packets).
module tb_noc_mmio_port;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_hit;
    logic [54:0] tx_packet;
    logic        tx_valid;
    logic        tx_ready;
    logic [54:0] rx_packet;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    int total = 0;
    int bad   = 0;

    noc_mmio_port dut (
        .clk       (clk),
        .reset     (reset),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_hit   (bus_hit),
        .tx_packet (tx_packet),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_packet (rx_packet),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_wr    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        @(posedge clk);
        #1;
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus_rd   = 1'b1;
        bus_addr = addr;
        @(posedge clk);
        #1;
        bus_rd = 1'b0;
        data   = bus_rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [54:0] exp_pkt;

        reset     = 1'b1;
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        tx_ready  = 1'b0;
        rx_packet = '0;
        rx_valid  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_rx_ready", 64'(rx_ready), 64'd1);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_bus_hit", 64'(bus_hit), 64'd0);
        chk("rst_rdata", 64'(bus_rdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic push: x=1, y=0, elem=DEADBEEF, drained immediately
        tx_ready = 1'b1;
        bus_write(BASE + 32'h00, 32'd1);
        bus_write(BASE + 32'h04, 32'd0);
        bus_write(BASE + 32'h20, 32'hDEAD_BEEF);
        chk("push_pre_valid", 64'(tx_valid), 64'd0);
        bus_write(BASE + 32'h24, 32'd0);
        chk("push_tx_valid", 64'(tx_valid), 64'd1);
        exp_pkt = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 32'hDEAD_BEEF};
        chk("push_tx_packet", 64'(tx_packet), 64'(exp_pkt));
        @(posedge clk);
        #1;
        chk("drain_tx_valid", 64'(tx_valid), 64'd0);

        // All fields populated; x retained from before
        tx_ready = 1'b0;
        bus_write(BASE + 32'h08, 32'd1);
        bus_write(BASE + 32'h0C, 32'd1);
        bus_write(BASE + 32'h10, 32'd2);
        bus_write(BASE + 32'h14, 32'd1);
        bus_write(BASE + 32'h18, 32'hFFFF_FFA5);
        bus_write(BASE + 32'h1C, 32'h0000_013C);
        bus_write(BASE + 32'h20, 32'hCAFE_F00D);
        bus_write(BASE + 32'h24, 32'd0);
        exp_pkt = {1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 8'hA5, 8'h3C, 32'hCAFE_F00D};
        chk("fields_tx_packet", 64'(tx_packet), 64'(exp_pkt));
        @(negedge clk);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        chk("fields_drained", 64'(tx_valid), 64'd0);

        // Five pushes into a 4-deep FIFO: one drop
        for (int i = 0; i < 5; i++) begin
            bus_write(BASE + 32'h24, 32'd0);
        end
        bus_read(BASE + 32'h2C, rd);
        chk("full_status", 64'(rd), 64'h0000_0400);
        chk("full_hit", 64'(bus_hit), 64'd1);
        bus_read(BASE + 32'h54, rd);
        chk("full_drop", 64'(rd), 64'd1);

        // Push while full with the network draining: no drop
        @(negedge clk);
        tx_ready  = 1'b1;
        bus_wr    = 1'b1;
        bus_addr  = BASE + 32'h24;
        @(posedge clk);
        #1;
        bus_wr   = 1'b0;
        tx_ready = 1'b0;
        bus_read(BASE + 32'h2C, rd);
        chk("pushpop_status", 64'(rd), 64'h0000_0400);
        bus_read(BASE + 32'h54, rd);
        chk("pushpop_drop", 64'(rd), 64'd1);
        bus_write(BASE + 32'h54, 32'd0);
        bus_read(BASE + 32'h54, rd);
        chk("drop_cleared", 64'(rd), 64'd0);
        bus_read(BASE + 32'h00, rd);
        chk("stage_wo_read", 64'(rd), 64'd0);

        // RX receive, read head fields, pop
        @(negedge clk);
        rx_packet = {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h77, 8'h00, 32'h1234_5678};
        rx_valid  = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("rx_irq_set", 64'(irq), 64'd1);
        bus_read(BASE + 32'h50, rd);
        chk("rx_elem", 64'(rd), 64'h1234_5678);
        bus_read(BASE + 32'h30, rd);
        chk("rx_x", 64'(rd), 64'd1);
        bus_read(BASE + 32'h48, rd);
        chk("rx_mx", 64'(rd), 64'h77);
        bus_read(BASE + 32'h2C, rd);
        chk("rx_status", 64'(rd), 64'h0001_0402);
        bus_write(BASE + 32'h28, 32'd0);
        chk("rx_irq_clr", 64'(irq), 64'd0);
        bus_read(BASE + 32'h50, rd);
        chk("rx_elem_empty", 64'(rd), 64'd0);
        bus_write(BASE + 32'h28, 32'd0);
        bus_read(BASE + 32'h2C, rd);
        chk("pop_empty_status", 64'(rd), 64'h0000_0400);

        // Out-of-window access
        bus_read(BASE + 32'h58, rd);
        chk("oow_hit", 64'(bus_hit), 64'd0);
        chk("oow_rdata_hold", 64'(rd), 64'h0000_0400);
        bus_write(BASE + 32'h58, 32'd0);
        chk("oow_wr_hit", 64'(bus_hit), 64'd0);
        bus_write(BASE - 32'h4, 32'd0);
        bus_read(BASE + 32'h2C, rd);
        chk("oow_no_change", 64'(rd), 64'h0000_0400);

        // Reset with three RX entries queued
        @(negedge clk);
        rx_packet = {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00, 32'h0000_00AA};
        rx_valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        bus_read(BASE + 32'h2C, rd);
        chk("rx3_status", 64'(rd), 64'h0003_0402);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_rx_count", 64'(dut.u_rx_fifo.count), 64'd0);
        chk("arst_rx_ready", 64'(rx_ready), 64'd1);
        chk("arst_irq", 64'(irq), 64'd0);
        chk("arst_tx_valid", 64'(tx_valid), 64'd0);
        chk("arst_rdata", 64'(bus_rdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(BASE + 32'h2C, rd);
        chk("post_rst_status", 64'(rd), 64'h0000_0001);

        // Fill RX: ready drops at four entries
        @(negedge clk);
        rx_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("rx_full_ready", 64'(rx_ready), 64'd0);
        bus_read(BASE + 32'h2C, rd);
        chk("rx_full_status", 64'(rd), 64'h0004_0003);
        bus_read(BASE + 32'h34, rd);
        chk("rx_y", 64'(rd), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
